// File: rtl/mix_col_pipe.sv
// Pipelined AES MixColumns / InvMixColumns engine with valid/ready handshake.
// Optional pass-through beats are enabled by defining MIXCOL_BYPASS_EN.
module mix_col_pipe #(
    parameter int COLS        = 1,
    parameter int PIPE_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic                in_bypass,
`endif
    input  logic [0:32*COLS-1]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_inv,
    output logic [0:32*COLS-1]  out_data
);

    localparam int W = 32 * COLS;

    logic           w_advance;
    logic [0:W-1]   w_mix;

    logic           r_valid [PIPE_STAGES];
    logic           r_inv   [PIPE_STAGES];
    logic [0:W-1]   r_data  [PIPE_STAGES];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Ready depends only on the output stage so it can never form a loop through in_valid.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    genvar gi, gr;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [7:0] w_a  [4];
            logic [7:0] w_x2 [4];
            logic [7:0] w_x4 [4];
            logic [7:0] w_x8 [4];

            for (gr = 0; gr < 4; gr++) begin : g_byte
                assign w_a[gr]  = in_data[32*gi + 8*gr +: 8];
                assign w_x2[gr] = xtime(w_a[gr]);
                assign w_x4[gr] = xtime(w_x2[gr]);
                assign w_x8[gr] = xtime(w_x4[gr]);
            end

            // Row gr sees the coefficient row rotated right by gr, i.e. byte gr+k gets coeff k.
            for (gr = 0; gr < 4; gr++) begin : g_row
                localparam int R1 = (gr + 1) % 4;
                localparam int R2 = (gr + 2) % 4;
                localparam int R3 = (gr + 3) % 4;
                logic [7:0] w_fwd;
                logic [7:0] w_inv;

                assign w_fwd = w_x2[gr]
                             ^ (w_x2[R1] ^ w_a[R1])
                             ^ w_a[R2]
                             ^ w_a[R3];
                assign w_inv = (w_x8[gr] ^ w_x4[gr] ^ w_x2[gr])
                             ^ (w_x8[R1] ^ w_x2[R1] ^ w_a[R1])
                             ^ (w_x8[R2] ^ w_x4[R2] ^ w_a[R2])
                             ^ (w_x8[R3] ^ w_a[R3]);
`ifdef MIXCOL_BYPASS_EN
                assign w_mix[32*gi + 8*gr +: 8] = in_bypass ? w_a[gr]
                                                : (in_inv ? w_inv : w_fwd);
`else
                assign w_mix[32*gi + 8*gr +: 8] = in_inv ? w_inv : w_fwd;
`endif
            end
        end
    endgenerate

    // All mixing happens ahead of stage 0; later stages are pure delay so the
    // final register drives the outputs with no logic behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_inv[i]   <= 1'b0;
                r_data[i]  <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_inv[0]  <= in_inv;
                r_data[0] <= w_mix;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_inv[i]   <= r_inv[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_inv   = r_inv[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];

endmodule
